// File: rtl/scrypt_blockmix_param.sv
// scryptBlockMix over 2R Salsa20/8 sub-blocks, one Salsa round per clock.
// Result slots: even sub-block i -> slot i/2, odd sub-block i -> slot R + i/2.
module scrypt_blockmix_param #(
  parameter int R = 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                enable,
  input  logic [1024*R-1:0]   data,
  output logic [1024*R-1:0]   hash_out,
  output logic                hash_done,
  output logic                busy
);

  localparam int NSUB = 2 * R;
  localparam logic [3:0] LAST_IDX = 4'(NSUB - 1);

  typedef enum logic [2:0] {IDLE, MIX, ROUND, ADD, DONE} state_t;

  state_t              state;
  logic [1024*R-1:0]   blk;
  logic [511:0]        x;
  logic [511:0]        save;
  logic [3:0]          idx;
  logic [2:0]          rnd;

  logic [511:0]        x_round;
  logic [511:0]        x_sum;
  logic [511:0]        blk_sel;
  logic [3:0]          slot;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Returns {a, b, c, d} after one Salsa quarter-round.
  function automatic logic [127:0] qr(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c, input logic [31:0] d);
    logic [31:0] ta, tb, tc, td, s;
    s  = a + d;
    tb = b ^ rotl(s, 7);
    s  = tb + a;
    tc = c ^ rotl(s, 9);
    s  = tc + tb;
    td = d ^ rotl(s, 13);
    s  = td + tc;
    ta = a ^ rotl(s, 18);
    return {ta, tb, tc, td};
  endfunction

  function automatic logic [511:0] salsa_round(input logic [511:0] in, input logic odd);
    logic [31:0]  w [16];
    logic [511:0] res;
    for (int k = 0; k < 16; k++) w[k] = in[32*k +: 32];
    if (!odd) begin
      {w[0],  w[4],  w[8],  w[12]} = qr(w[0],  w[4],  w[8],  w[12]);
      {w[5],  w[9],  w[13], w[1]}  = qr(w[5],  w[9],  w[13], w[1]);
      {w[10], w[14], w[2],  w[6]}  = qr(w[10], w[14], w[2],  w[6]);
      {w[15], w[3],  w[7],  w[11]} = qr(w[15], w[3],  w[7],  w[11]);
    end else begin
      {w[0],  w[1],  w[2],  w[3]}  = qr(w[0],  w[1],  w[2],  w[3]);
      {w[5],  w[6],  w[7],  w[4]}  = qr(w[5],  w[6],  w[7],  w[4]);
      {w[10], w[11], w[8],  w[9]}  = qr(w[10], w[11], w[8],  w[9]);
      {w[15], w[12], w[13], w[14]} = qr(w[15], w[12], w[13], w[14]);
    end
    for (int k = 0; k < 16; k++) res[32*k +: 32] = w[k];
    return res;
  endfunction

  function automatic logic [511:0] add_words(input logic [511:0] a, input logic [511:0] b);
    logic [511:0] res;
    for (int k = 0; k < 16; k++) res[32*k +: 32] = a[32*k +: 32] + b[32*k +: 32];
    return res;
  endfunction

  always_comb begin
    x_round = salsa_round(x, rnd[0]);
    x_sum   = add_words(x, save);
    blk_sel = blk[512*idx +: 512];
    slot    = idx[0] ? (4'(R) + {1'b0, idx[3:1]}) : {1'b0, idx[3:1]};
  end

  // hash_done and busy are registered, so both trail the DONE state by one clock.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      blk       <= '0;
      x         <= '0;
      save      <= '0;
      idx       <= '0;
      rnd       <= '0;
      hash_out  <= '0;
      hash_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          hash_done <= 1'b0;
          busy      <= 1'b0;
          if (enable) begin
            blk   <= data;
            x     <= data[512*(NSUB-1) +: 512];
            idx   <= '0;
            state <= MIX;
          end
        end
        MIX: begin
          busy  <= 1'b1;
          x     <= x ^ blk_sel;
          save  <= x ^ blk_sel;
          rnd   <= '0;
          state <= ROUND;
        end
        ROUND: begin
          x   <= x_round;
          rnd <= rnd + 3'd1;
          if (rnd == 3'd7) state <= ADD;
        end
        ADD: begin
          x                       <= x_sum;
          hash_out[512*slot +: 512] <= x_sum;
          if (idx == LAST_IDX) begin
            state <= DONE;
          end else begin
            idx   <= idx + 4'd1;
            state <= MIX;
          end
        end
        DONE: begin
          hash_done <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/scrypt_blockmix_param.md
SCRYPT_BLOCKMIX_PARAM -- requirements
Module: scrypt_blockmix_param

Interface
REQ-001 SHALL have parameter: R, default 1, scrypt block-size factor; block is 2R Salsa sub-blocks of 512 bits; legal range 1..8.
REQ-002 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port: n_rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: enable  input  1  start request, sampled only in IDLE.
REQ-005 SHALL have port: data  input  1024*R  input block B; sub-block j = data[512*j +: 512]; word w of a sub-block = bits [32*w +: 32].
REQ-006 SHALL have port: hash_out  output  1024*R  BlockMix result B', same packing as data.
REQ-007 SHALL have port: hash_done  output  1  one-cycle pulse, result valid.
REQ-008 SHALL have port: busy  output  1  high from start capture until the hash_done cycle, inclusive.

Function
REQ-009 SHALL compute scryptBlockMix with Salsa20/8: X = B[2R-1]; for i = 0..2R-1: X = Salsa20/8(X xor B[i]), Y[i] = X; B' = (Y0, Y2, ..., Y[2R-2], Y1, Y3, ..., Y[2R-1]).
REQ-010 SHALL implement Salsa20/8 as 8 rounds, alternating column round (even) and row round (odd), each round = 4 quarter-rounds on 16 x 32-bit words, rotations 7/9/13/18, then word-wise mod-2^32 add of the round input.
REQ-011 SHALL be a state machine with states IDLE, MIX, ROUND, ADD, DONE.
REQ-012 IDLE: on edge with enable=1, data SHALL be latched into an internal block register, X <= B[2R-1], sub-block index i <= 0, next MIX; enable=0 stays IDLE.
REQ-013 MIX (1 cycle): X <= X xor B[i], and a feed-forward copy SHALL be saved; round counter <= 0; next ROUND.
REQ-014 ROUND (exactly 8 cycles): one Salsa round per cycle; counter 7 -> ADD.
REQ-015 ADD (1 cycle): X <= X + saved copy (per 32-bit word, carries discarded), written to output slot i/2 if i even, R + i/2 if i odd; if i = 2R-1 -> DONE, else i <= i+1 -> MIX.
REQ-016 DONE (1 cycle): hash_done = 1; next IDLE.
REQ-017 Latency: enable sampled at edge k -> hash_done high during cycle after edge k+1+20R (21 cycles for R=1, 41 for R=2).
REQ-018 hash_out SHALL hold its value from DONE until the final ADD of the next operation; partial slots MAY update during an operation, only the DONE-cycle value is defined.
REQ-019 enable while busy=1 SHALL be ignored; no queueing; data changes after capture SHALL NOT affect the result.
REQ-020 enable high in the DONE cycle SHALL be ignored; enable high in the following IDLE cycle SHALL start a new operation (back-to-back period 2+20R cycles).
REQ-021 All arithmetic SHALL be 32-bit unsigned mod 2^32; no width growth.

Reset
REQ-022 n_rst=0 SHALL asynchronously force state IDLE, hash_out = 0, hash_done = 0, busy = 0, and clear X, saved copy, latched block, and counters.
REQ-023 Reset asserted mid-operation SHALL abort with no hash_done pulse; first enable after release SHALL start cleanly.

Verification
REQ-024 R=1, data = all zeros, enable pulsed one cycle -> hash_done exactly 21 cycles after capture edge, hash_out = all zeros, busy high for 21 cycles.
REQ-025 R=1, data word n = n (n = 0..31) -> hash_out bit-exact to software golden model; single hash_done pulse.
REQ-026 R=2, random 2048-bit data -> hash_done 41 cycles after capture; output order verified (Y0, Y2, Y1, Y3) vs golden model.
REQ-027 R=1, enable held high 60 cycles -> exactly two completions, at 21 and 43 cycles after first capture; data changed mid-run does not alter the first result.
REQ-028 n_rst pulsed low in ROUND of sub-block 1 -> outputs 0 immediately, no hash_done; restart with zero data yields zero output at 21 cycles.
